// File: rtl/disp_pkg.sv
// Shared constants and the control bundle for the text-mode display scanner.
package disp_pkg;

  localparam int COLS      = 64;
  localparam int ROWS      = 16;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;

  localparam int H_ACTIVE  = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_TOTAL   = 800;
  localparam int V_ACTIVE  = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_TOTAL   = 525;

  localparam int ADDR_W    = 10;
  localparam int CHAR_BITS = 8;
  localparam int LINE_BITS = 4;
  localparam int XPIX_BITS = 3;
  localparam int CNT_W     = 10;
  localparam int PIPE_LAT  = 6;

  // Beam-derived control carried alongside the fetch pipeline.
  typedef struct packed {
    logic                 de;
    logic                 hs;
    logic                 vs;
    logic                 in_text;
    logic                 fs;
    logic                 inv;
    logic [XPIX_BITS-1:0] xpix;
    logic [LINE_BITS-1:0] line;
  } scan_ctl_t;

endpackage

// File: rtl/disp_timing.sv
// Raster counters and raw (undelayed) de/hsync/vsync/text-window flags.
module disp_timing
  import disp_pkg::*;
#(
  parameter int COLS_P     = COLS,
  parameter int ROWS_P     = ROWS,
  parameter int CHAR_W_P   = CHAR_W,
  parameter int CHAR_H_P   = CHAR_H,
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int H_FP_P     = H_FP,
  parameter int H_SYNC_P   = H_SYNC,
  parameter int H_TOTAL_P  = H_TOTAL,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int V_FP_P     = V_FP,
  parameter int V_SYNC_P   = V_SYNC,
  parameter int V_TOTAL_P  = V_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             de0,
  output logic             hs0,
  output logic             vs0,
  output logic             in_text0,
  output logic             fs0
);

  logic [CNT_W-1:0] hcnt_reg;
  logic [CNT_W-1:0] vcnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (hcnt_reg == CNT_W'(H_TOTAL_P - 1)) begin
      hcnt_reg <= '0;
      vcnt_reg <= (vcnt_reg == CNT_W'(V_TOTAL_P - 1)) ? '0 : vcnt_reg + 1'b1;
    end else begin
      hcnt_reg <= hcnt_reg + 1'b1;
    end
  end

  assign hcnt     = hcnt_reg;
  assign vcnt     = vcnt_reg;
  assign de0      = (hcnt_reg < CNT_W'(H_ACTIVE_P)) && (vcnt_reg < CNT_W'(V_ACTIVE_P));
  assign hs0      = (hcnt_reg >= CNT_W'(H_ACTIVE_P + H_FP_P)) &&
                    (hcnt_reg <  CNT_W'(H_ACTIVE_P + H_FP_P + H_SYNC_P));
  assign vs0      = (vcnt_reg >= CNT_W'(V_ACTIVE_P + V_FP_P)) &&
                    (vcnt_reg <  CNT_W'(V_ACTIVE_P + V_FP_P + V_SYNC_P));
  assign in_text0 = (hcnt_reg < CNT_W'(COLS_P * CHAR_W_P)) && (vcnt_reg < CNT_W'(ROWS_P * CHAR_H_P));
  assign fs0      = (hcnt_reg == '0) && (vcnt_reg == '0);

endmodule

// File: rtl/disp_text_scan.sv
// Character RAM read scanner: beam -> RAM address -> font ROM -> serial pixel.
// Optional blinking cell cursor when DISP_CURSOR_EN is defined.
module disp_text_scan
  import disp_pkg::*;
#(
  parameter int   COLS_P     = COLS,
  parameter int   ROWS_P     = ROWS,
  parameter int   CHAR_W_P   = CHAR_W,
  parameter int   CHAR_H_P   = CHAR_H,
  parameter int   H_ACTIVE_P = H_ACTIVE,
  parameter int   H_FP_P     = H_FP,
  parameter int   H_SYNC_P   = H_SYNC,
  parameter int   H_TOTAL_P  = H_TOTAL,
  parameter int   V_ACTIVE_P = V_ACTIVE,
  parameter int   V_FP_P     = V_FP,
  parameter int   V_SYNC_P   = V_SYNC,
  parameter int   V_TOTAL_P  = V_TOTAL,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef DISP_CURSOR_EN
  input  logic [ADDR_W-1:0]              cursor_addr,
`endif
  output logic [ADDR_W-1:0]              ram_addr,
  input  logic [CHAR_BITS-1:0]           ram_q,
  output logic [CHAR_BITS+LINE_BITS-1:0] font_addr,
  input  logic [CHAR_BITS-1:0]           font_q,
  output logic                           pixel,
  output logic                           de,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           frame_start
);

  localparam int COL_SH = $clog2(CHAR_W_P);
  localparam int ROW_SH = $clog2(CHAR_H_P);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic de0, hs0, vs0, in_text0, fs0;

  disp_timing #(
    .COLS_P(COLS_P), .ROWS_P(ROWS_P), .CHAR_W_P(CHAR_W_P), .CHAR_H_P(CHAR_H_P),
    .H_ACTIVE_P(H_ACTIVE_P), .H_FP_P(H_FP_P), .H_SYNC_P(H_SYNC_P), .H_TOTAL_P(H_TOTAL_P),
    .V_ACTIVE_P(V_ACTIVE_P), .V_FP_P(V_FP_P), .V_SYNC_P(V_SYNC_P), .V_TOTAL_P(V_TOTAL_P)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .de0      (de0),
    .hs0      (hs0),
    .vs0      (vs0),
    .in_text0 (in_text0),
    .fs0      (fs0)
  );

  logic [ADDR_W-1:0] row_idx;
  logic [ADDR_W-1:0] col_idx;
  logic [ADDR_W-1:0] addr_next;
  scan_ctl_t         ctl0;

`ifdef DISP_CURSOR_EN
  logic [4:0] frame_cnt_reg;
`endif

  always_comb begin
    row_idx   = ADDR_W'(vcnt >> ROW_SH);
    col_idx   = ADDR_W'(hcnt >> COL_SH);
    addr_next = ADDR_W'(row_idx * ADDR_W'(COLS_P)) + col_idx;

    ctl0         = '0;
    ctl0.de      = de0;
    ctl0.hs      = hs0;
    ctl0.vs      = vs0;
    ctl0.in_text = in_text0;
    ctl0.fs      = fs0;
    ctl0.xpix    = hcnt[XPIX_BITS-1:0];
    ctl0.line    = vcnt[LINE_BITS-1:0];
`ifdef DISP_CURSOR_EN
    // Cursor cell blinks with a 32-frame period, lit in the upper half.
    ctl0.inv     = frame_cnt_reg[4] && in_text0 && (addr_next == cursor_addr);
`endif
  end

  // Stage k of the delay line holds the control word of the beam position
  // whose data is currently at fetch stage k.
  scan_ctl_t pipe_reg [1:PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < PIPE_LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[1] <= ctl0;
      for (int i = 2; i < PIPE_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  logic [ADDR_W-1:0]              ram_addr_reg;
  logic [CHAR_BITS+LINE_BITS-1:0] font_addr_reg;
  logic                           pixel_reg, de_reg, hs_reg, vs_reg, fs_reg;
  logic [XPIX_BITS-1:0]           xpix_idx;
  logic                           glyph_bit;

  // font_q bit 7 is the leftmost pixel of the cell.
  assign xpix_idx  = XPIX_BITS'(CHAR_W_P - 1) - pipe_reg[PIPE_LAT-1].xpix;
  assign glyph_bit = font_q[xpix_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_reg  <= '0;
      font_addr_reg <= '0;
      pixel_reg     <= 1'b0;
      de_reg        <= 1'b0;
      hs_reg        <= ~SYNC_POL;
      vs_reg        <= ~SYNC_POL;
      fs_reg        <= 1'b0;
    end else begin
      ram_addr_reg  <= addr_next;
      font_addr_reg <= {ram_q, pipe_reg[3].line};
      pixel_reg     <= pipe_reg[PIPE_LAT-1].in_text & (glyph_bit ^ pipe_reg[PIPE_LAT-1].inv);
      de_reg        <= pipe_reg[PIPE_LAT-1].de;
      hs_reg        <= pipe_reg[PIPE_LAT-1].hs ? SYNC_POL : ~SYNC_POL;
      vs_reg        <= pipe_reg[PIPE_LAT-1].vs ? SYNC_POL : ~SYNC_POL;
      fs_reg        <= pipe_reg[PIPE_LAT-1].fs;
    end
  end

`ifdef DISP_CURSOR_EN
  always_ff @(posedge clk) begin
    if (reset) frame_cnt_reg <= '0;
    else if (fs_reg) frame_cnt_reg <= frame_cnt_reg + 1'b1;
  end
`endif

  assign ram_addr    = ram_addr_reg;
  assign font_addr   = font_addr_reg;
  assign pixel       = pixel_reg;
  assign de          = de_reg;
  assign hsync       = hs_reg;
  assign vsync       = vs_reg;
  assign frame_start = fs_reg;

endmodule

// File: tb/tb_disp_text_scan.sv
// Scoreboard bench for disp_text_scan: expectations are queued with the cycle
// at which they must hold; a negedge monitor pops and compares them.
module tb_disp_text_scan;

  // Vertical timing is shortened (56 lines, 2 text rows) so a full frame and a
  // mid-frame reset fit in a short run; horizontal timing is the standard one.
  localparam int VA = 48, VF = 2, VS = 2, VT = 56, ROWS_T = 2;
  localparam int HT = 800;
  localparam int FRAME = HT * VT;

  typedef enum int {S_PIX, S_DE, S_HS, S_VS, S_FS, S_RA, S_FA} sig_e;
  typedef struct {
    int        cyc;
    sig_e      sig;
    logic [11:0] exp;
    string     name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_q;
  logic [11:0] font_addr;
  logic [7:0]  font_q;
  logic        pixel, de, hsync, vsync, frame_start;
`ifdef DISP_CURSOR_EN
  logic [9:0]  cursor_addr = 10'd0;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  disp_text_scan #(.ROWS_P(ROWS_T), .V_ACTIVE_P(VA), .V_FP_P(VF), .V_SYNC_P(VS), .V_TOTAL_P(VT)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef DISP_CURSOR_EN
    .cursor_addr (cursor_addr),
`endif
    .ram_addr    (ram_addr),
    .ram_q       (ram_q),
    .font_addr   (font_addr),
    .font_q      (font_q),
    .pixel       (pixel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  // Char RAM read port: 2-cycle latency. Font ROM: 1-cycle latency.
  logic [7:0] ram_mem [0:1023];
  logic [7:0] rom_mem [0:4095];
  logic [9:0] ram_a_reg;
  always @(posedge clk) begin
    ram_a_reg <= ram_addr;
    ram_q     <= ram_mem[ram_a_reg];
    font_q    <= rom_mem[font_addr];
  end

  function automatic void push(input int c, input sig_e s, input logic [11:0] v, input string n);
    exp_t e;
    int   pos;
    e.cyc = c; e.sig = s; e.exp = v; e.name = n;
    pos = sb_q.size();
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].cyc > c) begin pos = i; break; end
    end
    sb_q.insert(pos, e);
  endfunction

  function automatic logic [11:0] sample(input sig_e s);
    case (s)
      S_PIX:   return {11'd0, pixel};
      S_DE:    return {11'd0, de};
      S_HS:    return {11'd0, hsync};
      S_VS:    return {11'd0, vsync};
      S_FS:    return {11'd0, frame_start};
      S_RA:    return {2'd0, ram_addr};
      default: return font_addr;
    endcase
  endfunction

  // Monitor: every expectation due at this cycle is compared against the DUT.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      logic [11:0] act;
      e = sb_q.pop_front();
      checks++;
      act = sample(e.sig);
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s missed: due cycle %0d, seen at %0d", e.name, e.cyc, cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", e.name, cyc, act, e.exp);
      end
    end
  end

  int         base, base2;
  logic [7:0] g;

  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = 8'hFF;
    ram_mem[0] = 8'h41;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
    for (int l = 0; l < 16; l++) rom_mem[{8'hFF, 4'(l)}] = 8'hFF;
    rom_mem[12'h410] = 8'h81;
    rom_mem[12'h411] = 8'h00;

    reset = 1'b1;
    push(2, S_DE, 12'd0, "rst_de");
    push(2, S_PIX, 12'd0, "rst_pixel");
    push(2, S_HS, 12'd1, "rst_hsync");
    push(2, S_VS, 12'd1, "rst_vsync");
    push(2, S_FS, 12'd0, "rst_fs");
    push(2, S_RA, 12'd0, "rst_ram_addr");
    push(2, S_FA, 12'd0, "rst_font_addr");
    $display("vec reset held 3 clocks");

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = cyc;
    $display("vec release at cycle %0d", base);

    // Output at base+k belongs to beam position k-6; ram_addr to k-1; font_addr to k-4.
    push(base + 5, S_DE, 12'd0, "first_de_early");
    push(base + 6, S_DE, 12'd1, "first_de");
    push(base + 5, S_FS, 12'd0, "fs_early");
    push(base + 6, S_FS, 12'd1, "fs_first");
    push(base + 7, S_FS, 12'd0, "fs_pulse_end");
    push(base + 6 + FRAME - 1, S_FS, 12'd0, "fs_before_frame2");
    push(base + 6 + FRAME, S_FS, 12'd1, "fs_frame2");
    push(base + 6 + FRAME + 1, S_FS, 12'd0, "fs_frame2_end");

    push(base + 661, S_HS, 12'd1, "hs_before_fall");
    push(base + 662, S_HS, 12'd0, "hs_fall");
    push(base + 757, S_HS, 12'd0, "hs_last_active");
    push(base + 758, S_HS, 12'd1, "hs_rise");
    push(base + 662 + HT - 1, S_HS, 12'd1, "hs2_before_fall");
    push(base + 662 + HT, S_HS, 12'd0, "hs2_fall");

    push(base + 6 + 49 * HT + 799, S_VS, 12'd1, "vs_line49");
    push(base + 6 + 50 * HT, S_VS, 12'd0, "vs_line50");
    push(base + 6 + 51 * HT + 799, S_VS, 12'd0, "vs_line51");
    push(base + 6 + 52 * HT, S_VS, 12'd1, "vs_line52");
    $display("vec timing: hsync, vsync, frame_start");

    push(base + 1, S_RA, 12'd0, "ra_00");
    push(base + 1 + 8, S_RA, 12'd1, "ra_h8_v0");
    push(base + 1 + 16 * HT + 8, S_RA, 12'd65, "ra_h8_v16");
    push(base + 1 + 31 * HT + 511, S_RA, 12'd127, "ra_h511_v31");
    push(base + 4, S_FA, 12'h410, "fa_line0");
    push(base + 4 + HT, S_FA, 12'h411, "fa_line1");
    push(base + 4 + 8, S_FA, 12'hFF0, "fa_cell1");
    $display("vec address mapping");

    g = 8'h81;
    for (int h = 0; h < 8; h++) push(base + 6 + h, S_PIX, {11'd0, g[7-h]}, "glyph_line0");
    for (int h = 0; h < 8; h++) push(base + 6 + HT + h, S_PIX, 12'd0, "glyph_line1");
    push(base + 6 + HT + 8, S_PIX, 12'd1, "line1_cell1");
    for (int h = 8; h < 640; h++) push(base + 6 + h, S_PIX, (h < 512) ? 12'd1 : 12'd0, "window_pixel");
    for (int h = 500; h < 650; h++) push(base + 6 + h, S_DE, (h < 640) ? 12'd1 : 12'd0, "window_de");
    push(base + 6 + 799, S_DE, 12'd0, "de_line_end");
    push(base + 6 + 16 * HT, S_PIX, 12'd1, "row1_pixel");
    push(base + 6 + 32 * HT, S_PIX, 12'd0, "below_text_pixel");
    push(base + 6 + 32 * HT, S_DE, 12'd1, "below_text_de");
    push(base + 6 + 48 * HT, S_DE, 12'd0, "vblank_de");
    $display("vec glyph path and window edge");

    // Mid-frame reset when the counters sit at (100,20) in frame 2.
    push(base + FRAME + 20 * HT + 100, S_PIX, 12'd1, "pre_reset_pixel");
    push(base + FRAME + 20 * HT + 100, S_DE, 12'd1, "pre_reset_de");
    while (cyc < base + FRAME + 20 * HT + 100) @(negedge clk);
    reset = 1'b1;
    push(cyc + 1, S_DE, 12'd0, "midrst_de");
    push(cyc + 1, S_PIX, 12'd0, "midrst_pixel");
    push(cyc + 1, S_FS, 12'd0, "midrst_fs");
    push(cyc + 1, S_HS, 12'd1, "midrst_hsync");
    push(cyc + 1, S_RA, 12'd0, "midrst_ram_addr");
    $display("vec mid-frame reset at cycle %0d", cyc);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base2 = cyc;
    for (int k = 1; k < 6; k++) begin
      push(base2 + k, S_FS, 12'd0, "rerel_fs_early");
      push(base2 + k, S_DE, 12'd0, "rerel_de_early");
      push(base2 + k, S_PIX, 12'd0, "rerel_no_glyph");
    end
    push(base2 + 6, S_FS, 12'd1, "rerel_fs");
    push(base2 + 6, S_DE, 12'd1, "rerel_de");
    push(base2 + 6, S_PIX, 12'd1, "rerel_pixel");
    $display("vec re-release at cycle %0d", base2);

    for (int n = 0; n < 50 && sb_q.size() > 0; n++) @(negedge clk);
    @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared: due cycle %0d, now %0d", e.name, e.cyc, cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
